stove_controller: RTL and testbench
===================================

STOVE_CONTROLLER -- requirements
Module: stove_controller

Interface
REQ-001 The block SHALL have parameter TICKS_PER_STEP, default 100_000_000, meaning basys_clk cycles per cook step (1 s).
REQ-002 The block SHALL have parameter DONE_STEP, default 10, meaning the progress value at which food is cooked.
REQ-003 The block SHALL have parameter BURN_STEP, default 15, meaning the progress value at which food burns; BURN_STEP > DONE_STEP >= 1 and BURN_STEP <= 15.
REQ-004 The block SHALL have port basys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port add_btn, input, 1 bit: debounced level; press = add item or start cooking.
REQ-007 The block SHALL have port take_btn, input, 1 bit: debounced level; press = remove the finished dish.
REQ-008 The block SHALL have port held_item, input, 3 bits: player's carried item; 0 none, 1-6 ingredient, 7 reserved.
REQ-009 The block SHALL have port stove_inventory, output, 12 bits: 4 slots x 3 bits, slot0 = [2:0], slot3 = [11:9]; 0 = empty; feeds the stove renderer.
REQ-010 The block SHALL have port cook_progress, output, 4 bits: current cook step.
REQ-011 The block SHALL have port stove_state, output, 3 bits: IDLE=0, LOADING=1, COOKING=2, DONE=3, BURNT=4.
REQ-012 The block SHALL have port dish, output, 12 bits: inventory snapshot at take.
REQ-013 The block SHALL have port dish_valid, output, 1 bit: one-cycle pulse qualifying dish.
REQ-014 The block SHALL have port dish_burnt, output, 1 bit: qualifies dish; valid only while dish_valid is 1.

Function
REQ-015 Edge detect: registered previous value per button; rise = btn AND NOT prev; each action SHALL take effect on the same clock edge at which the rise is sampled; a level held high SHALL produce exactly one action.
REQ-016 If rise_take and rise_add occur on the same edge, the block SHALL process take only and discard add.
REQ-017 IDLE/LOADING, add rise, held_item in 1-6, fewer than 4 items loaded: the block SHALL write held_item into the lowest-numbered empty slot and enter LOADING.
REQ-018 Add rise with 4 items loaded, or held_item = 7: the block SHALL not change inventory or state (full/invalid).
REQ-019 LOADING, add rise, held_item = 0: the block SHALL enter COOKING, clear cook_progress to 0, clear the prescaler to 0.
REQ-020 IDLE, add rise, held_item = 0: the block SHALL do nothing (no start on empty).
REQ-021 COOKING/DONE: the prescaler SHALL count 0..TICKS_PER_STEP-1 and wrap; on each wrap, cook_progress SHALL increment by 1; add rises SHALL be ignored.
REQ-022 On the edge cook_progress becomes DONE_STEP: the block SHALL enter DONE.
REQ-023 On the edge cook_progress becomes BURN_STEP: the block SHALL enter BURNT, set all occupied slots to 7 (burnt), and stop the prescaler; cook_progress SHALL hold at BURN_STEP and never wrap.
REQ-024 DONE or BURNT, take rise: on the same edge, the block SHALL load dish with stove_inventory (pre-clear value), drive dish_valid=1, set dish_burnt=1 if BURNT else 0, clear inventory to 0 and cook_progress to 0, and enter IDLE.
REQ-025 dish_valid SHALL be 1 for exactly one cycle per take; dish and dish_burnt SHALL hold their values until the next take.
REQ-026 Take rises in IDLE, LOADING or COOKING SHALL be ignored.
REQ-027 Empty slots SHALL stay 0 through BURNT; only occupied slots become 7.

Reset
REQ-028 With reset=1 at a clock edge, the block SHALL set stove_inventory=0, cook_progress=0, stove_state=IDLE, dish=0, dish_valid=0, dish_burnt=0, and the prescaler to 0; this overrides all other events, including mid-cook.
REQ-029 Reset SHALL set both button prev registers to 1, so a button held through reset release produces no action until released and pressed again.

Verification (TICKS_PER_STEP=4, DONE_STEP=10, BURN_STEP=15)
REQ-030 Load: add rises with held_item=3, then 5 -> stove_inventory=12'h02B, state=LOADING; fifth add with 4 items loaded -> unchanged.
REQ-031 Cook/done: load item 3, add rise with held_item=0 -> COOKING; cook_progress=10 and state=DONE exactly 40 cycles later; take rise -> dish=12'h003, dish_valid pulse of 1 cycle, dish_burnt=0, state IDLE, inventory 0.
REQ-032 Burn: load items 1 and 2, start, no take -> at 60 cycles state=BURNT, inventory=12'h03F, progress stays 15 for a further 100 cycles; take -> dish=12'h03F, dish_burnt=1.
REQ-033 Simultaneous: in DONE, add and take rise on the same edge -> take processed, state IDLE, no item loaded.
REQ-034 Reset mid-cook with add_btn held high: assert reset at progress 6 -> all outputs 0 and state IDLE; deassert reset with add_btn still high -> no action until add_btn goes low and rises again.

Source files
------------

// File: rtl/stove_controller.sv
// Stove controller: loads up to four ingredients, cooks on a prescaled step
// timer, flags done and burnt, and hands the dish out on a take press.
//
// state   | meaning
// IDLE    | stove empty, waiting for the first ingredient
// LOADING | 1-4 ingredients in, waiting for more or for an empty-handed start
// COOKING | step timer running, food not yet cooked
// DONE    | food cooked, timer still running toward burn
// BURNT   | food burnt, timer stopped, progress pinned at BURN_STEP
module stove_controller #(
   parameter int TICKS_PER_STEP = 100_000_000,
   parameter int DONE_STEP      = 10,
   parameter int BURN_STEP      = 15
) (
   input  logic        basys_clk,
   input  logic        reset,
   input  logic        add_btn,
   input  logic        take_btn,
   input  logic [2:0]  held_item,
   output logic [11:0] stove_inventory,
   output logic [3:0]  cook_progress,
   output logic [2:0]  stove_state,
   output logic [11:0] dish,
   output logic        dish_valid,
   output logic        dish_burnt
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOADING = 3'd1,
      S_COOKING = 3'd2,
      S_DONE    = 3'd3,
      S_BURNT   = 3'd4
   } state_t;

   localparam int            PW     = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
   localparam logic [PW-1:0] C_LAST = PW'(TICKS_PER_STEP - 1);
   localparam logic [3:0]    C_DONE = 4'(DONE_STEP);
   localparam logic [3:0]    C_BURN = 4'(BURN_STEP);

   state_t        r_state;
   logic [11:0]   r_inv;
   logic [3:0]    r_progress;
   logic [PW-1:0] r_presc;
   logic          r_add_prev;
   logic          r_take_prev;
   logic [11:0]   r_dish;
   logic          r_dish_valid;
   logic          r_dish_burnt;

   logic          w_rise_add;
   logic          w_rise_take;
   logic          w_has_empty;
   logic [1:0]    w_slot;
   logic          w_item_ok;
   logic [3:0]    w_prog_next;

   assign w_rise_add  = add_btn & ~r_add_prev;
   assign w_rise_take = take_btn & ~r_take_prev;
   assign w_item_ok   = (held_item != 3'd0) && (held_item != 3'd7);
   assign w_prog_next = r_progress + 4'd1;

   // Slots fill lowest-first and only ever clear together, so the lowest
   // empty slot is also the next one to load.
   always_comb begin
      w_slot      = 2'd0;
      w_has_empty = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (r_inv[i*3 +: 3] == 3'd0) begin
            w_slot      = 2'(i);
            w_has_empty = 1'b1;
         end
      end
   end

   always_ff @(posedge basys_clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_inv        <= '0;
         r_progress   <= '0;
         r_presc      <= '0;
         r_add_prev   <= 1'b1;
         r_take_prev  <= 1'b1;
         r_dish       <= '0;
         r_dish_valid <= 1'b0;
         r_dish_burnt <= 1'b0;
      end else begin
         r_add_prev   <= add_btn;
         r_take_prev  <= take_btn;
         r_dish_valid <= 1'b0;
         if (w_rise_take && (r_state == S_DONE || r_state == S_BURNT)) begin
            r_dish       <= r_inv;
            r_dish_valid <= 1'b1;
            r_dish_burnt <= (r_state == S_BURNT);
            r_inv        <= '0;
            r_progress   <= '0;
            r_presc      <= '0;
            r_state      <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE, S_LOADING: begin
                  if (w_rise_add && !w_rise_take) begin
                     if (w_item_ok && w_has_empty) begin
                        for (int i = 0; i < 4; i++) begin
                           if (2'(i) == w_slot) r_inv[i*3 +: 3] <= held_item;
                        end
                        r_state <= S_LOADING;
                     end else if (held_item == 3'd0 && r_state == S_LOADING) begin
                        r_progress <= '0;
                        r_presc    <= '0;
                        r_state    <= S_COOKING;
                     end
                  end
               end
               S_COOKING, S_DONE: begin
                  if (r_presc == C_LAST) begin
                     r_presc    <= '0;
                     r_progress <= w_prog_next;
                     if (w_prog_next == C_BURN) begin
                        for (int i = 0; i < 4; i++) begin
                           if (r_inv[i*3 +: 3] != 3'd0) r_inv[i*3 +: 3] <= 3'd7;
                        end
                        r_state <= S_BURNT;
                     end else if (w_prog_next == C_DONE) begin
                        r_state <= S_DONE;
                     end
                  end else begin
                     r_presc <= r_presc + PW'(1);
                  end
               end
               S_BURNT: ;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign stove_inventory = r_inv;
   assign cook_progress   = r_progress;
   assign stove_state     = r_state;
   assign dish            = r_dish;
   assign dish_valid      = r_dish_valid;
   assign dish_burnt      = r_dish_burnt;

endmodule

// File: tb/tb_stove_controller.sv
// Self-checking bench for stove_controller with a 4-tick cook step.
module tb_stove_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        add_btn;
   logic        take_btn;
   logic [2:0]  held_item;
   logic [11:0] stove_inventory;
   logic [3:0]  cook_progress;
   logic [2:0]  stove_state;
   logic [11:0] dish;
   logic        dish_valid;
   logic        dish_burnt;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [12:0] sb_q[$];
   logic        prev_dv = 1'b0;

   localparam logic [2:0] IDLE = 3'd0, LOADING = 3'd1, COOKING = 3'd2, DONE = 3'd3, BURNT = 3'd4;

   stove_controller #(.TICKS_PER_STEP(4), .DONE_STEP(10), .BURN_STEP(15)) dut (
      .basys_clk(clk), .reset(reset), .add_btn(add_btn), .take_btn(take_btn),
      .held_item(held_item), .stove_inventory(stove_inventory),
      .cook_progress(cook_progress), .stove_state(stove_state), .dish(dish),
      .dish_valid(dish_valid), .dish_burnt(dish_burnt));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Dish scoreboard: expected {burnt, dish} is queued when take is driven.
   always @(negedge clk) begin
      if (dish_valid) begin
         chk("dv_one_cycle", 16'(prev_dv), 16'd0);
         if (sb_q.size() == 0) chk("dish_unexpected", 16'd1, 16'd0);
         else chk("dish", 16'({dish_burnt, dish}), 16'(sb_q.pop_front()));
      end
      prev_dv = dish_valid;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_add(input logic [2:0] item);
      held_item = item; add_btn = 1'b1; step(1);
      add_btn = 1'b0; step(1);
   endtask

   task automatic press_take();
      take_btn = 1'b1; step(1);
      take_btn = 1'b0; step(1);
   endtask

   task automatic do_reset();
      reset = 1'b1; step(2);
      reset = 1'b0; step(1);
   endtask

   // Start cooking; returns just after the start edge.
   task automatic start_cook();
      held_item = 3'd0; add_btn = 1'b1; step(1);
      add_btn = 1'b0;
   endtask

   initial begin
      reset = 1'b1; add_btn = 1'b0; take_btn = 1'b0; held_item = 3'd0;
      do_reset();
      chk("rst_state", 16'(stove_state), 16'(IDLE));
      chk("rst_inv", 16'(stove_inventory), 16'h000);
      chk("rst_dish", 16'({dish_valid, dish_burnt, dish}), 16'h0000);

      press_add(3'd3);
      press_add(3'd5);
      chk("load2_inv", 16'(stove_inventory), 16'h02B);
      chk("load2_state", 16'(stove_state), 16'(LOADING));
      press_add(3'd1);
      press_add(3'd2);
      chk("load4_inv", 16'(stove_inventory), 16'h46B);
      press_add(3'd4);
      chk("full_inv", 16'(stove_inventory), 16'h46B);
      press_add(3'd7);
      chk("item7_inv", 16'(stove_inventory), 16'h46B);
      press_take();
      chk("take_loading", 16'(stove_state), 16'(LOADING));
      do_reset();

      press_add(3'd0);
      chk("idle_empty_start", 16'(stove_state), 16'(IDLE));
      press_add(3'd3);
      start_cook();
      chk("cook_start", 16'({stove_state, cook_progress}), 16'({COOKING, 4'd0}));
      step(39);
      chk("pre_done", 16'({stove_state, cook_progress}), 16'({COOKING, 4'd9}));
      step(1);
      chk("done_at_40", 16'({stove_state, cook_progress}), 16'({DONE, 4'd10}));
      press_add(3'd4);
      chk("add_in_done", 16'(stove_inventory), 16'h003);
      sb_q.push_back({1'b0, 12'h003});
      press_take();
      chk("after_take", 16'({stove_state, cook_progress, stove_inventory}), 16'({IDLE, 4'd0, 12'h000}) & 16'hFFFF);
      chk("after_take_st", 16'(stove_state), 16'(IDLE));
      step(3);
      chk("dish_hold", 16'({dish_valid, dish_burnt, dish}), 16'h0003);

      press_add(3'd1);
      press_add(3'd2);
      start_cook();
      step(59);
      chk("pre_burn", 16'({stove_state, cook_progress}), 16'({DONE, 4'd14}));
      step(1);
      chk("burn_at_60", 16'({stove_state, cook_progress}), 16'({BURNT, 4'd15}));
      chk("burn_inv", 16'(stove_inventory), 16'h03F);
      step(100);
      chk("burn_hold", 16'({stove_state, cook_progress}), 16'({BURNT, 4'd15}));
      sb_q.push_back({1'b1, 12'h03F});
      press_take();
      chk("burn_take_st", 16'(stove_state), 16'(IDLE));

      press_add(3'd3);
      start_cook();
      step(40);
      chk("sim_done", 16'(stove_state), 16'(DONE));
      sb_q.push_back({1'b0, 12'h003});
      held_item = 3'd4; add_btn = 1'b1; take_btn = 1'b1; step(1);
      chk("sim_state", 16'(stove_state), 16'(IDLE));
      chk("sim_inv", 16'(stove_inventory), 16'h000);
      add_btn = 1'b0; take_btn = 1'b0; step(2);
      chk("sim_inv2", 16'(stove_inventory), 16'h000);

      press_add(3'd2);
      start_cook();
      step(24);
      chk("mid_prog", 16'(cook_progress), 16'd6);
      held_item = 3'd3; add_btn = 1'b1; reset = 1'b1; step(1);
      chk("mid_rst_out", 16'({stove_inventory, cook_progress}), 16'h0000);
      chk("mid_rst_misc", 16'({stove_state, dish_valid, dish_burnt}), 16'h0000);
      chk("mid_rst_dish", 16'(dish), 16'h000);
      reset = 1'b0; step(3);
      chk("held_no_act", 16'({stove_state, stove_inventory}), 16'h0000);
      add_btn = 1'b0; step(1);
      add_btn = 1'b1; step(1);
      chk("repress_inv", 16'(stove_inventory), 16'h003);
      chk("repress_st", 16'(stove_state), 16'(LOADING));
      add_btn = 1'b0; step(2);

      chk("sb_drained", 16'(sb_q.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
